// File: rtl/ila_readout_engine_if.sv
// Byte-stream link from the ILA readout engine to the host transport.
interface ila_readout_engine_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;

    modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
    modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/ila_readout_engine.sv
// Streams a completed ILA capture out of sample memory as bytes, LSB first, oldest sample first.
// Optional 4-byte header enabled by defining ILA_READOUT_HEADER_EN.
module ila_readout_engine #(
    parameter int unsigned SAMPLE_WIDTH = 32,
    parameter int unsigned DEPTH        = 1024,
    localparam int unsigned ADDR_BITS   = $clog2(DEPTH),
    localparam int unsigned NBYTES      = (SAMPLE_WIDTH + 7) / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_BITS-1:0]    base_ptr,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_BITS-1:0]    mem_rd_addr,
    input  logic [SAMPLE_WIDTH-1:0] mem_rd_data,
    ila_readout_engine_if.master    tx
);

    // One spare byte above the sample so the "next byte" slice is always in range.
    localparam int unsigned SHW       = NBYTES * 8 + 8;
    localparam int unsigned BIDX_BITS = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam bit          ONE_BYTE  = (NBYTES == 1);

`ifdef ILA_READOUT_HEADER_EN
    typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_FETCH, ST_WAIT, ST_SEND, ST_DONE} state_t;
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = 8'(NBYTES);
            2'd2:    hdr_byte = DEPTH_W[7:0];
            default: hdr_byte = DEPTH_W[15:8];
        endcase
    endfunction

    logic [1:0] hdr_idx_q, hdr_idx_d;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_SEND, ST_DONE} state_t;
`endif

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   cnt_inc;
    logic [BIDX_BITS-1:0]   bidx_q, bidx_d;
    logic [BIDX_BITS-1:0]   bidx_next;
    logic [SHW-1:0]         shreg_q, shreg_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_BITS-1:0]   mem_rd_addr_q, mem_rd_addr_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_last_q, tx_last_d;
    logic                   xfer;
    logic                   last_byte;
    logic                   last_sample;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            cnt_q         <= '0;
            bidx_q        <= '0;
            shreg_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_last_q     <= 1'b0;
`ifdef ILA_READOUT_HEADER_EN
            hdr_idx_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            cnt_q         <= cnt_d;
            bidx_q        <= bidx_d;
            shreg_q       <= shreg_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            tx_last_q     <= tx_last_d;
`ifdef ILA_READOUT_HEADER_EN
            hdr_idx_q     <= hdr_idx_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        cnt_d         = cnt_q;
        bidx_d        = bidx_q;
        shreg_d       = shreg_q;
        done_d        = 1'b0;
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = mem_rd_addr_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        tx_last_d     = tx_last_q;
`ifdef ILA_READOUT_HEADER_EN
        hdr_idx_d     = hdr_idx_q;
`endif
        xfer        = tx_valid_q && tx.tx_ready;
        last_byte   = (bidx_q == BIDX_BITS'(NBYTES - 1));
        last_sample = (cnt_q == ADDR_BITS'(DEPTH - 1));
        cnt_inc     = cnt_q + ADDR_BITS'(1);
        bidx_next   = bidx_q + BIDX_BITS'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d = base_ptr;
                    cnt_d  = '0;
`ifdef ILA_READOUT_HEADER_EN
                    state_d    = ST_HEADER;
                    hdr_idx_d  = 2'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = hdr_byte(2'd0);
                    tx_last_d  = 1'b0;
`else
                    state_d       = ST_FETCH;
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = base_ptr;
`endif
                end
            end
`ifdef ILA_READOUT_HEADER_EN
            ST_HEADER: begin
                if (xfer) begin
                    if (hdr_idx_q == 2'd3) begin
                        state_d       = ST_FETCH;
                        tx_valid_d    = 1'b0;
                        mem_rd_en_d   = 1'b1;
                        mem_rd_addr_d = base_q;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                        tx_data_d = hdr_byte(hdr_idx_q + 2'd1);
                    end
                end
            end
`endif
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is valid this cycle; load it and present byte 0.
                state_d    = ST_SEND;
                shreg_d    = SHW'(mem_rd_data);
                bidx_d     = '0;
                tx_valid_d = 1'b1;
                tx_data_d  = shreg_d[7:0];
                tx_last_d  = ONE_BYTE && last_sample;
            end
            ST_SEND: begin
                if (xfer) begin
                    if (last_byte) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        if (last_sample) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d         = cnt_inc;
                            state_d       = ST_FETCH;
                            mem_rd_en_d   = 1'b1;
                            mem_rd_addr_d = base_q + cnt_inc;
                        end
                    end else begin
                        bidx_d    = bidx_next;
                        shreg_d   = shreg_q >> 8;
                        tx_data_d = shreg_q[15:8];
                        tx_last_d = (bidx_next == BIDX_BITS'(NBYTES - 1)) && last_sample;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a byte handshaking this cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            done_d      = 1'b0;
            mem_rd_en_d = 1'b0;
            tx_valid_d  = 1'b0;
            tx_last_d   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_last  = tx_last_q;

endmodule

// File: tb/tb_ila_readout_engine.sv
// Randomized scoreboard bench for ila_readout_engine (SAMPLE_WIDTH=12, DEPTH=4).
module tb_ila_readout_engine;

    localparam int unsigned SW = 12;
    localparam int unsigned D  = 4;
    localparam int unsigned AB = 2;
    localparam int unsigned NB = 2;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AB-1:0] base_ptr;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AB-1:0] mem_rd_addr;
    logic [SW-1:0] mem_rd_data;

    ila_readout_engine_if tx_if ();

    ila_readout_engine #(.SAMPLE_WIDTH(SW), .DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .base_ptr    (base_ptr),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .tx          (tx_if)
    );

    logic [SW-1:0] mem [D];
    byte_t         exp_q [$];
    logic [AB-1:0] addr_q [$];
    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    int            cyc      = 0;
    int            done_due = -1;
    int            done_cnt = 0;
    int            acc_cnt  = 0;
    int            ready_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous capture memory: data one cycle after the read strobe
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: the readout is the header (if any) then every sample oldest-first, LSB byte first.
    task automatic push_model(input int base);
        logic [31:0] s;
        byte_t       e;
`ifdef ILA_READOUT_HEADER_EN
        logic [31:0] dw;
        dw = 32'(D);
        e.l = 1'b0;
        e.d = 8'hA5;     exp_q.push_back(e);
        e.d = 8'(NB);    exp_q.push_back(e);
        e.d = dw[7:0];   exp_q.push_back(e);
        e.d = dw[15:8];  exp_q.push_back(e);
`endif
        for (int i = 0; i < int'(D); i++) begin
            int a;
            a = (base + i) % int'(D);
            addr_q.push_back(AB'(a));
            s = 32'(mem[a]);
            for (int b = 0; b < int'(NB); b++) begin
                e.d = s[8*b +: 8];
                e.l = (i == int'(D) - 1) && (b == int'(NB) - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // tx_ready driver
    initial begin
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_if.tx_ready = 1'b1;
                1:       tx_if.tx_ready = ~tx_if.tx_ready;
                default: tx_if.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every presented byte, read strobe and done pulse against the queues
    initial begin
        byte_t         e;
        logic [AB-1:0] ea;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_rd_en) begin
                    if (addr_q.size() == 0) check(1'b0, "extra_mem_rd", mem_rd_addr, 0);
                    else begin
                        ea = addr_q.pop_front();
                        check(mem_rd_addr == ea, "mem_rd_addr", mem_rd_addr, ea);
                    end
                end
                if (tx_if.tx_valid) begin
                    if (exp_q.size() == 0) check(1'b0, "extra_tx_byte", tx_if.tx_data, 0);
                    else begin
                        e = exp_q[0];
                        check(tx_if.tx_data == e.d, "tx_data", tx_if.tx_data, e.d);
                        check(tx_if.tx_last == e.l, "tx_last", tx_if.tx_last, e.l);
                        check(busy == 1'b1, "busy_while_valid", busy, 1);
                        if (tx_if.tx_ready) begin
                            void'(exp_q.pop_front());
                            acc_cnt++;
                            if (e.l) done_due = cyc + 1;
                        end
                    end
                end
                if (cyc == done_due) begin
                    check(done == 1'b1, "done_timing", done, 1);
                    if (done) done_cnt++;
                    done_due = -1;
                end else if (done) begin
                    check(1'b0, "spurious_done", done, 0);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int base);
        @(posedge clk);
        #1;
        base_ptr = AB'(base);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_readout(input int base, input int mode, input bit extra_start);
        int  prev;
        bit  ok;
        ready_mode = mode;
        push_model(base);
        prev = done_cnt;
        pulse_start(base);
        if (extra_start) begin
            wait_cycles(5);
            base_ptr = AB'($urandom);
            start    = 1'b1;
            wait_cycles(1);
            start = 1'b0;
        end
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (done_cnt > prev) begin
                ok = 1'b1;
                break;
            end
        end
        check(ok, "readout_done_timeout", done_cnt, prev + 1);
        check(busy == 1'b0, "busy_after_done", busy, 0);
        check(exp_q.size() == 0, "bytes_left", exp_q.size(), 0);
        check(addr_q.size() == 0, "reads_left", addr_q.size(), 0);
        wait_cycles(2);
    endtask

    task automatic wait_accepted(input int target, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (acc_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check(ok, name, acc_cnt, target);
    endtask

    task automatic check_outputs_zero(input string name);
        check({busy, done, mem_rd_en, tx_if.tx_valid, tx_if.tx_last} == 5'b0, name,
              {busy, done, mem_rd_en, tx_if.tx_valid, tx_if.tx_last}, 0);
        check(tx_if.tx_data == 8'h00 && mem_rd_addr == '0, {name, "_data_addr"},
              {tx_if.tx_data, 6'b0, mem_rd_addr}, 0);
    endtask

    initial begin
        int dc;
        bit ok;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        base_ptr = '0;
        for (int i = 0; i < int'(D); i++) mem[i] = SW'(12'hA00 + i);
        wait_cycles(3);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        wait_cycles(2);

        // Directed: contiguous, toggled back-pressure, wrapping base
        run_readout(2, 0, 1'b0);
        run_readout(2, 1, 1'b0);
        run_readout(3, 0, 1'b0);

        // Abort on the third accepted byte
        ready_mode = 0;
        push_model(1);
        pulse_start(1);
        wait_accepted(acc_cnt + 2, "abort_wait_two");
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (tx_if.tx_valid) begin
                ok = 1'b1;
                break;
            end
            wait_cycles(1);
        end
        check(ok, "abort_wait_third", tx_if.tx_valid, 1);
        abort = 1'b1;
        wait_cycles(1);
        abort = 1'b0;
        check(tx_if.tx_valid == 1'b0, "abort_tx_valid", tx_if.tx_valid, 0);
        check(busy == 1'b0, "abort_busy", busy, 0);
        check(mem_rd_en == 1'b0, "abort_mem_rd_en", mem_rd_en, 0);
        exp_q.delete();
        addr_q.delete();
        dc = done_cnt;
        wait_cycles(10);
        check(done_cnt == dc, "abort_no_done", done_cnt, dc);
        check(tx_if.tx_valid == 1'b0, "abort_idle_quiet", tx_if.tx_valid, 0);
        run_readout(1, 0, 1'b0);

        // Asynchronous reset in the middle of sending
        ready_mode = 0;
        push_model(0);
        pulse_start(0);
        wait_accepted(acc_cnt + 3, "reset_wait_send");
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();
        addr_q.delete();
        done_due = -1;
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(10);
        check({busy, mem_rd_en, tx_if.tx_valid} == 3'b0, "post_reset_quiet",
              {busy, mem_rd_en, tx_if.tx_valid}, 0);
        run_readout(2, 0, 1'b0);

        // Randomized contents, base and back-pressure; some with a stray start while busy
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < int'(D); i++) mem[i] = SW'($urandom);
            run_readout(int'($urandom_range(0, D - 1)), (r % 3 == 0) ? 1 : 2, r[0]);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
